// File: rtl/openddr_cfg_apb_master.sv
// APB master for the OpenDDR configuration slave: request FIFO, one outstanding APB transfer, in-order responses.
// Optional build macro OPENDDR_APB_MST_ALIGN_CHK_EN rejects word-misaligned addresses without touching the bus.
module openddr_cfg_apb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [9:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        psel,
  output logic        penable,
  output logic        pwr,
  output logic [9:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int EW = 43;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_next;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic          head_misaligned;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr, tmo_inc, load, capture, cap_err;
  logic [31:0]   cap_rdata;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  // Held low while in reset so every output reads 0 until release
  assign req_ready = rst_n && !full;
  assign push = req_valid && !full;
  assign head = mem[rd_ptr];

`ifdef OPENDDR_APB_MST_ALIGN_CHK_EN
  assign head_misaligned = (head[33:32] != 2'b00);
`else
  assign head_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_wr, req_addr, req_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    cap_rdata  = '0;
    cap_err    = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_misaligned) begin
            capture    = 1'b1;
            cap_err    = 1'b1;
            state_next = RESP;
          end else begin
            load       = 1'b1;
            tmo_clr    = 1'b1;
            state_next = SETUP;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (pready) begin
          capture    = 1'b1;
          cap_rdata  = (pwr || pslverr) ? 32'h0 : prdata;
          cap_err    = pslverr;
          state_next = RESP;
        end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          capture    = 1'b1;
          cap_err    = 1'b1;
          state_next = RESP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus address/data registers only change on a pop that starts a real transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddr     <= '0;
      pwr       <= 1'b0;
      pwdata    <= '0;
      tmo_cnt   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (load) begin
        pwr    <= head[42];
        paddr  <= head[41:32];
        pwdata <= head[31:0];
      end
      if (tmo_clr)      tmo_cnt <= '0;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + TW'(1);
      if (capture) begin
        rsp_rdata <= cap_rdata;
        rsp_err   <= cap_err;
      end
    end
  end

  assign psel      = (state == SETUP) || (state == ACCESS);
  assign penable   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign busy      = !empty || (state != IDLE);
endmodule
